// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: memory address/data plus the decode-side valid/ready handshake and redirect.
interface instruction_fetch_unit_if;
  logic [31:0] instruction_address_o;
  logic [31:0] instruction_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;

  modport master (
    output instruction_address_o,
    output fetch_valid_o,
    output fetch_instr_o,
    output fetch_pc_o,
    input  instruction_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  fetch_ready_i
  );

  modport slave (
    input  instruction_address_o,
    input  fetch_valid_o,
    input  fetch_instr_o,
    input  fetch_pc_o,
    output instruction_i,
    output redirect_i,
    output redirect_pc_i,
    output fetch_ready_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register feeding a 2-entry {pc, instr} FIFO toward decode.
// Redirect flushes the FIFO and reloads the PC; reset overrides everything.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        valid;
  logic        deq;
  logic        enq;

  assign valid = (count != 2'd0);
  assign deq   = valid && bus.fetch_ready_i;
  assign enq   = !bus.redirect_i && ((count < 2'd2) || deq);

  assign bus.instruction_address_o = {pc[31:2], 2'b00};
  assign bus.fetch_valid_o         = valid;
  assign bus.fetch_instr_o         = fifo_instr[rd_ptr];
  assign bus.fetch_pc_o            = fifo_pc[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc     <= RESET_PC_ALIGNED;
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (bus.redirect_i) begin
      // A concurrent dequeue is still consumed by decode; the flush discards the rest.
      pc     <= {bus.redirect_pc_i[31:2], 2'b00};
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (enq) begin
        pc     <= pc + 32'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is deliberately unreset; it is only observed when count != 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enq) begin
      fifo_pc[wr_ptr]    <= {pc[31:2], 2'b00};
      fifo_instr[wr_ptr] <= bus.instruction_i;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus reset/stall/wrap sequences.
module tb_instruction_fetch_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if wbus ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (wbus)
  );

  // Memory model: word k holds 32'h1000_0000 + k.
  assign bus.instruction_i  = 32'h1000_0000 + {2'b00, bus.instruction_address_o[31:2]};
  assign wbus.instruction_i = 32'h1000_0000 + {2'b00, wbus.instruction_address_o[31:2]};
  assign wbus.redirect_i    = 1'b0;
  assign wbus.redirect_pc_i = 32'h0;
  assign wbus.fetch_ready_i = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.fetch_ready_i = ready;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    // Outputs are checked for the current cycle, then inputs applied for the next edge.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h1000_0000, 32'h0000_0004};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h1000_0001, 32'h0000_0008};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h1000_0001, 32'h0000_000C};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'h1000_0001, 32'h0000_000C};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h1000_0002, 32'h0000_0010};
    vecs[6]  = '{1'b1, 1'b1, 32'h103, 1'b1, 32'hC,   32'h1000_0003, 32'h0000_0014};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         32'h0000_0100};
    vecs[8]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'h100, 32'h1000_0040, 32'h0000_0104};
    vecs[9]  = '{1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   32'h0,         32'h0000_0040};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,         32'h0000_0080};
    vecs[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h80,  32'h1000_0020, 32'h0000_0084};
    vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h84,  32'h1000_0021, 32'h0000_0088};

    do_reset(1'b1);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("v%0d_valid", i), {31'b0, bus.fetch_valid_o}, {31'b0, vecs[i].ev});
      check($sformatf("v%0d_addr", i), bus.instruction_address_o, vecs[i].eaddr);
      if (vecs[i].ev) begin
        check($sformatf("v%0d_pc", i), bus.fetch_pc_o, vecs[i].epc);
        check($sformatf("v%0d_instr", i), bus.fetch_instr_o, vecs[i].einstr);
      end
      bus.fetch_ready_i = vecs[i].ready;
      bus.redirect_i    = vecs[i].redir;
      bus.redirect_pc_i = vecs[i].rpc;
      tick();
    end

    // Stall for 5 cycles from reset: FIFO fills, PC holds at 8, then drains in order.
    do_reset(1'b0);
    repeat (5) tick();
    check("stall_addr", bus.instruction_address_o, 32'h8);
    check("stall_valid", {31'b0, bus.fetch_valid_o}, 32'h1);
    bus.fetch_ready_i = 1'b1;
    begin
      int got = 0;
      for (int c = 0; c < 10 && got < 3; c++) begin
        if (bus.fetch_valid_o) begin
          check($sformatf("drain_pc%0d", got), bus.fetch_pc_o, 32'(got * 4));
          check($sformatf("drain_instr%0d", got), bus.fetch_instr_o, 32'h1000_0000 + 32'(got));
          got++;
        end
        tick();
      end
      check("drain_count", 32'(got), 32'd3);
    end

    // Reset while full and redirecting: reset wins.
    do_reset(1'b0);
    tick();
    tick();
    check("full_before_rst", {31'b0, bus.fetch_valid_o}, 32'h1);
    rst_i = 1'b1;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h200;
    tick();
    check("rst_ovr_valid", {31'b0, bus.fetch_valid_o}, 32'h0);
    check("rst_ovr_addr", bus.instruction_address_o, 32'h0);
    rst_i = 1'b0;
    bus.redirect_i = 1'b0;
    check("post_rst_addr", bus.instruction_address_o, 32'h0);
    check("post_rst_valid", {31'b0, bus.fetch_valid_o}, 32'h0);

    // Wrap-around instance: fetched pcs cross 2^32.
    do_reset(1'b1);
    check("wrap_first_addr", wbus.instruction_address_o, 32'hFFFF_FFF8);
    begin
      logic [31:0] exp_pcs [4];
      int got = 0;
      exp_pcs[0] = 32'hFFFF_FFF8;
      exp_pcs[1] = 32'hFFFF_FFFC;
      exp_pcs[2] = 32'h0000_0000;
      exp_pcs[3] = 32'h0000_0004;
      for (int c = 0; c < 20 && got < 4; c++) begin
        if (wbus.fetch_valid_o) begin
          check($sformatf("wrap_pc%0d", got), wbus.fetch_pc_o, exp_pcs[got]);
          got++;
        end
        tick();
      end
      check("wrap_count", 32'(got), 32'd4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset; bits [1:0] SHALL be treated as zero.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port instruction_address_o, output, 32 bits: word-aligned fetch address to main memory, driven directly from the PC register.
REQ-005 The block SHALL have port instruction_i, input, 32 bits: instruction word returned combinationally by memory in the same cycle.
REQ-006 The block SHALL have port redirect_i, input, 1 bit: branch/jump taken; flush and refetch.
REQ-007 The block SHALL have port redirect_pc_i, input, 32 bits: redirect target; bits [1:0] SHALL be ignored (forced 0).
REQ-008 The block SHALL have port fetch_ready_i, input, 1 bit: decode accepts the head entry this cycle.
REQ-009 The block SHALL have port fetch_valid_o, output, 1 bit: the head entry is valid.
REQ-010 The block SHALL have port fetch_instr_o, output, 32 bits: the head entry instruction.
REQ-011 The block SHALL have port fetch_pc_o, output, 32 bits: the head entry PC.

Function
REQ-012 The block SHALL hold a PC register and a 2-entry FIFO of {pc, instr} pairs, with a 2-bit occupancy count in the range 0..2.
REQ-013 instruction_address_o SHALL equal the PC register at all times, with bits [1:0] = 0.
REQ-014 A dequeue SHALL occur when fetch_valid_o && fetch_ready_i; fetch_valid_o SHALL be high when and only when count != 0.
REQ-015 An enqueue SHALL occur when !redirect_i && (count < 2 || dequeue); it SHALL write {PC, instruction_i} at the tail and advance PC <= PC + 4.
REQ-016 When no enqueue occurs and redirect_i is low, PC SHALL hold; the same address SHALL be re-presented until it is captured.
REQ-017 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 SHALL give 32'h0000_0000, with no flag.
REQ-018 Simultaneous enqueue and dequeue SHALL leave count unchanged: at count 2 the head advances and the new entry fills the freed slot; at count 1 the new entry becomes head next cycle.
REQ-019 Latency SHALL be 1 cycle: an instruction presented in cycle N SHALL appear on the fetch outputs no earlier than cycle N+1.
REQ-020 Redirect SHALL have priority over all other events: when redirect_i is high, the block SHALL set count <= 0, PC <= {redirect_pc_i[31:2], 2'b00}, and perform no enqueue in that cycle.
REQ-021 A dequeue presented in the same cycle as a redirect SHALL still be counted as consumed by decode, and the FIFO SHALL be flushed regardless.
REQ-022 After a redirect in cycle N, fetch_valid_o SHALL be low in cycle N+1, and the target instruction SHALL be valid in cycle N+2.
REQ-023 Back-to-back redirects SHALL each override the previous one; only the last target SHALL be fetched.
REQ-024 FIFO entries SHALL keep their order; fetch_instr_o and fetch_pc_o SHALL stay stable while fetch_valid_o && !fetch_ready_i && !redirect_i.
REQ-025 When count == 0, fetch_instr_o and fetch_pc_o SHALL be don't-care; the bench SHALL NOT check them in that state.

Reset
REQ-026 When rst_i is high at a clock edge, the block SHALL set PC <= RESET_PC, count <= 0, and the FIFO read/write pointers <= 0; FIFO data SHALL be left unreset.
REQ-027 rst_i SHALL override redirect_i and all handshakes, including when it is asserted mid-stream with the FIFO full.
REQ-028 In the first cycle after rst_i deasserts, the block SHALL drive instruction_address_o = RESET_PC and fetch_valid_o = 0.

Verification
REQ-029 Reset release with fetch_ready_i=1 and memory word k = 32'h1000_0000+k -> fetch_valid_o high from cycle 1; the bench SHALL see pc 0,4,8,... with instr 32'h1000_0000, 32'h1000_0001, ..., one entry per cycle.
REQ-030 fetch_ready_i=0 for 5 cycles from reset -> count reaches 2 and PC holds at 8; on release, the bench SHALL see pc 0,4,8 in order with none dropped or duplicated.
REQ-031 Redirect to 32'h0000_0103 while the FIFO is full -> in the next cycle fetch_valid_o=0 and instruction_address_o=32'h0000_0100; the cycle after, fetch_pc_o=32'h100.
REQ-032 Two consecutive redirects to 32'h40 then 32'h80 -> no entry with pc 32'h40 is ever valid; the first valid pc is 32'h80.
REQ-033 With RESET_PC=32'hFFFF_FFF8 -> the bench SHALL see fetched pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 rst_i asserted while count=2 and redirect_i=1 -> in the next cycle count=0, fetch_valid_o=0, and PC=RESET_PC (not the redirect target).
